// File: rtl/sdram_arbiter.sv
// Central SDRAM command arbiter: holds the pins for init, then grants refresh,
// write and read one at a time (refresh first, write/read round-robin).
module sdram_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sdram_init_done_flag,
   input  logic [3:0]  init_cmds,
   input  logic [12:0] init_addrs,
   input  logic        sdram_aref_req,
   output logic        sdram_aref_en,
   input  logic        sdram_aref_done,
   input  logic [3:0]  aref_cmds,
   input  logic [12:0] aref_addrs,
   input  logic        wr_req,
   output logic        wr_en,
   input  logic        wr_done,
   input  logic [3:0]  wr_cmds,
   input  logic [1:0]  wr_ba,
   input  logic [12:0] wr_addrs,
   input  logic        rd_req,
   output logic        rd_en,
   input  logic        rd_done,
   input  logic [3:0]  rd_cmds,
   input  logic [1:0]  rd_ba,
   input  logic [12:0] rd_addrs,
   output logic        aref_pending,
   output logic [3:0]  sdram_cmds,
   output logic [1:0]  sdram_ba,
   output logic [12:0] sdram_addrs
);

   typedef enum logic [2:0] {
      S_INIT,
      S_ARB,
      S_AREF,
      S_WRITE,
      S_READ
   } state_t;

   localparam logic [3:0] CMD_NOP = 4'b0111;

   state_t r_state;
   state_t w_next;
   logic   r_last_wr;
   logic   r_aref_pending;
   logic   r_aref_en;
   logic   r_wr_en;
   logic   r_rd_en;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT:  if (sdram_init_done_flag) w_next = S_ARB;
         S_ARB: begin
            if (r_aref_pending)          w_next = S_AREF;
            else if (wr_req && rd_req)   w_next = r_last_wr ? S_READ : S_WRITE;
            else if (wr_req)             w_next = S_WRITE;
            else if (rd_req)             w_next = S_READ;
         end
         S_AREF:  if (sdram_aref_done) w_next = S_ARB;
         S_WRITE: if (wr_done)         w_next = S_ARB;
         S_READ:  if (rd_done)         w_next = S_ARB;
         default: w_next = S_INIT;
      endcase
   end

   // Grants are registered so each pulse lands on the first cycle of its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_INIT;
         r_last_wr      <= 1'b0;
         r_aref_pending <= 1'b0;
         r_aref_en      <= 1'b0;
         r_wr_en        <= 1'b0;
         r_rd_en        <= 1'b0;
      end else begin
         r_state        <= w_next;
         r_aref_pending <= sdram_aref_req | (r_aref_pending & ~r_aref_en);
         r_aref_en      <= (r_state == S_ARB) && (w_next == S_AREF);
         r_wr_en        <= (r_state == S_ARB) && (w_next == S_WRITE);
         r_rd_en        <= (r_state == S_ARB) && (w_next == S_READ);
         if (r_state == S_ARB && w_next == S_WRITE)
            r_last_wr <= 1'b1;
         else if (r_state == S_ARB && w_next == S_READ)
            r_last_wr <= 1'b0;
      end
   end

   // Muxing on the current state keeps the source's done-cycle command on the pins.
   always_comb begin
      sdram_cmds  = CMD_NOP;
      sdram_ba    = 2'd0;
      sdram_addrs = 13'd0;
      case (r_state)
         S_INIT: begin
            sdram_cmds  = init_cmds;
            sdram_addrs = init_addrs;
         end
         S_AREF: begin
            sdram_cmds  = aref_cmds;
            sdram_addrs = aref_addrs;
         end
         S_WRITE: begin
            sdram_cmds  = wr_cmds;
            sdram_ba    = wr_ba;
            sdram_addrs = wr_addrs;
         end
         S_READ: begin
            sdram_cmds  = rd_cmds;
            sdram_ba    = rd_ba;
            sdram_addrs = rd_addrs;
         end
         default: ;
      endcase
   end

   assign sdram_aref_en = r_aref_en;
   assign wr_en         = r_wr_en;
   assign rd_en         = r_rd_en;
   assign aref_pending  = r_aref_pending;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: a service-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sdram_arbiter;

   logic        clk;
   logic        rst_n;
   logic        sdram_init_done_flag;
   logic [3:0]  init_cmds;
   logic [12:0] init_addrs;
   logic        sdram_aref_req;
   logic        sdram_aref_en;
   logic        sdram_aref_done;
   logic [3:0]  aref_cmds;
   logic [12:0] aref_addrs;
   logic        wr_req;
   logic        wr_en;
   logic        wr_done;
   logic [3:0]  wr_cmds;
   logic [1:0]  wr_ba;
   logic [12:0] wr_addrs;
   logic        rd_req;
   logic        rd_en;
   logic        rd_done;
   logic [3:0]  rd_cmds;
   logic [1:0]  rd_ba;
   logic [12:0] rd_addrs;
   logic        aref_pending;
   logic [3:0]  sdram_cmds;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_addrs;

   int checks = 0;
   int errors = 0;

   sdram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .sdram_init_done_flag(sdram_init_done_flag),
      .init_cmds(init_cmds), .init_addrs(init_addrs),
      .sdram_aref_req(sdram_aref_req), .sdram_aref_en(sdram_aref_en),
      .sdram_aref_done(sdram_aref_done),
      .aref_cmds(aref_cmds), .aref_addrs(aref_addrs),
      .wr_req(wr_req), .wr_en(wr_en), .wr_done(wr_done),
      .wr_cmds(wr_cmds), .wr_ba(wr_ba), .wr_addrs(wr_addrs),
      .rd_req(rd_req), .rd_en(rd_en), .rd_done(rd_done),
      .rd_cmds(rd_cmds), .rd_ba(rd_ba), .rd_addrs(rd_addrs),
      .aref_pending(aref_pending),
      .sdram_cmds(sdram_cmds), .sdram_ba(sdram_ba), .sdram_addrs(sdram_addrs)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: which service owns the bus, pending refresh, fairness memory, and
   // which grant (if any) was issued on the edge that opened this cycle.
   localparam int SVC_INIT = 0, SVC_IDLE = 1, SVC_REF = 2, SVC_WR = 3, SVC_RD = 4;
   int mSvc    = SVC_INIT;
   int mGrant  = SVC_IDLE;
   bit mPend   = 1'b0;
   bit mLastWr = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      int choice;
      int newGrant;
      if (!rst_n) begin
         mSvc    = SVC_INIT;
         mGrant  = SVC_IDLE;
         mPend   = 1'b0;
         mLastWr = 1'b0;
      end else begin
         newGrant = SVC_IDLE;
         if (mSvc == SVC_INIT) begin
            if (sdram_init_done_flag) mSvc = SVC_IDLE;
         end else if (mSvc == SVC_IDLE) begin
            if (mPend)                choice = SVC_REF;
            else if (wr_req && rd_req) choice = mLastWr ? SVC_RD : SVC_WR;
            else if (wr_req)          choice = SVC_WR;
            else if (rd_req)          choice = SVC_RD;
            else                      choice = SVC_IDLE;
            mSvc     = choice;
            newGrant = choice;
            if (choice == SVC_WR) mLastWr = 1'b1;
            if (choice == SVC_RD) mLastWr = 1'b0;
         end else if ((mSvc == SVC_REF && sdram_aref_done) ||
                      (mSvc == SVC_WR && wr_done) ||
                      (mSvc == SVC_RD && rd_done)) begin
            mSvc = SVC_IDLE;
         end
         mPend  = sdram_aref_req || (mPend && mGrant != SVC_REF);
         mGrant = newGrant;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [3:0]  eCmd;
      logic [1:0]  eBa;
      logic [12:0] eAddr;
      eCmd = 4'b0111; eBa = 2'd0; eAddr = 13'd0;
      case (mSvc)
         SVC_INIT: begin eCmd = init_cmds; eAddr = init_addrs; end
         SVC_REF:  begin eCmd = aref_cmds; eAddr = aref_addrs; end
         SVC_WR:   begin eCmd = wr_cmds; eBa = wr_ba; eAddr = wr_addrs; end
         SVC_RD:   begin eCmd = rd_cmds; eBa = rd_ba; eAddr = rd_addrs; end
         default: ;
      endcase
      checkOutput("model_aref_en", 32'(sdram_aref_en), 32'(mGrant == SVC_REF));
      checkOutput("model_wr_en",   32'(wr_en),         32'(mGrant == SVC_WR));
      checkOutput("model_rd_en",   32'(rd_en),         32'(mGrant == SVC_RD));
      checkOutput("model_pending", 32'(aref_pending),  32'(mPend));
      checkOutput("model_cmds",    32'(sdram_cmds),    32'(eCmd));
      checkOutput("model_ba",      32'(sdram_ba),      32'(eBa));
      checkOutput("model_addrs",   32'(sdram_addrs),   32'(eAddr));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Waits for a write or read grant; returns 1 for write, 2 for read, 0 on timeout.
   task automatic waitGrant(output int who);
      who = 0;
      for (int c = 0; c < 12 && who == 0; c++) begin
         @(negedge clk);
         if (wr_en) who = 1;
         else if (rd_en) who = 2;
      end
   endtask

   task automatic applyStimulus;
      int who;
      int expOrder [4];
      expOrder = '{2, 1, 2, 1};

      rst_n = 1'b1;
      sdram_init_done_flag = 1'b0;
      init_cmds = 4'b1010; init_addrs = 13'h0AAA;
      sdram_aref_req = 1'b0; sdram_aref_done = 1'b0;
      aref_cmds = 4'b0111; aref_addrs = 13'h0400;
      wr_req = 1'b0; wr_done = 1'b0; wr_cmds = 4'b0100; wr_ba = 2'd1; wr_addrs = 13'h0123;
      rd_req = 1'b0; rd_done = 1'b0; rd_cmds = 4'b0101; rd_ba = 2'd2; rd_addrs = 13'h0456;
      #2 rst_n = 1'b0;
      #6;
      checkOutput("reset_cmds",    32'(sdram_cmds),  32'h0000_000A);
      checkOutput("reset_addrs",   32'(sdram_addrs), 32'h0000_0AAA);
      checkOutput("reset_ba",      32'(sdram_ba),    32'd0);
      checkOutput("reset_pending", 32'(aref_pending), 32'd0);
      checkOutput("reset_grants",  32'({sdram_aref_en, wr_en, rd_en}), 32'd0);
      tick(1);
      rst_n = 1'b1;

      // Refresh requested while still initialising is held until ARB.
      tick(3);
      sdram_aref_req = 1'b1;
      tick(1);
      sdram_aref_req = 1'b0;
      @(negedge clk);
      checkOutput("init_pending_held", 32'(aref_pending), 32'd1);
      checkOutput("init_pins", 32'(sdram_cmds), 32'h0000_000A);
      tick(2);
      sdram_init_done_flag = 1'b1;
      wr_req = 1'b1;
      @(negedge clk);
      checkOutput("init_last_cycle", 32'(sdram_cmds), 32'h0000_000A);
      tick(1);
      @(negedge clk);
      checkOutput("arb_nop", 32'(sdram_cmds), 32'h0000_0007);
      checkOutput("arb_no_grant", 32'({sdram_aref_en, wr_en, rd_en}), 32'd0);
      tick(1);
      @(negedge clk);
      checkOutput("first_grant_aref", 32'({sdram_aref_en, wr_en, rd_en}), 32'h4);

      // Two-cycle refresh done: command reaches pins, single return to ARB.
      tick(1);
      aref_cmds = 4'b0001;
      sdram_aref_done = 1'b1;
      @(negedge clk);
      checkOutput("aref_cmd_on_done", 32'(sdram_cmds), 32'h0000_0001);
      tick(1);
      @(negedge clk);
      checkOutput("after_aref_nop", 32'(sdram_cmds), 32'h0000_0007);
      checkOutput("no_aref_regrant", 32'(sdram_aref_en), 32'd0);
      tick(1);
      sdram_aref_done = 1'b0;
      aref_cmds = 4'b0111;
      @(negedge clk);
      checkOutput("write_grant", 32'(wr_en), 32'd1);
      checkOutput("write_pins", 32'({sdram_cmds, sdram_ba}), 32'({4'b0100, 2'd1}));

      // Refresh request during a write jumps ahead of the still-pending write.
      sdram_aref_req = 1'b1;
      tick(1);
      sdram_aref_req = 1'b0;
      wr_done = 1'b1;
      @(negedge clk);
      checkOutput("pending_in_write", 32'(aref_pending), 32'd1);
      tick(1);
      wr_done = 1'b0;
      @(negedge clk);
      checkOutput("burst_gap_nop", 32'(sdram_cmds), 32'h0000_0007);
      tick(1);
      @(negedge clk);
      checkOutput("aref_before_write", 32'({sdram_aref_en, wr_en, rd_en}), 32'h4);
      tick(1);
      sdram_aref_done = 1'b1;
      tick(1);
      sdram_aref_done = 1'b0;
      tick(1);
      @(negedge clk);
      checkOutput("write_after_aref", 32'(wr_en), 32'd1);
      wr_done = 1'b1;
      tick(1);
      wr_done = 1'b0;
      wr_req = 1'b0;

      // Round-robin with both requests held; last service was a write.
      wr_req = 1'b1;
      rd_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         waitGrant(who);
         checkOutput($sformatf("rr_order_%0d", i), 32'(who), 32'(expOrder[i]));
         if (who == 1) wr_done = 1'b1;
         else if (who == 2) rd_done = 1'b1;
         tick(1);
         wr_done = 1'b0;
         rd_done = 1'b0;
      end
      wr_req = 1'b0;
      rd_req = 1'b0;

      // Reset in the middle of a read with a refresh pending.
      tick(2);
      rd_req = 1'b1;
      waitGrant(who);
      checkOutput("read_grant", 32'(who), 32'd2);
      rd_req = 1'b0;
      sdram_aref_req = 1'b1;
      tick(1);
      sdram_aref_req = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midread_reset_pins", 32'({sdram_cmds, sdram_ba, sdram_addrs}),
                  32'({4'b1010, 2'd0, 13'h0AAA}));
      checkOutput("midread_reset_pending", 32'(aref_pending), 32'd0);
      checkOutput("midread_reset_grants", 32'({sdram_aref_en, wr_en, rd_en}), 32'd0);
      tick(1);
      rst_n = 1'b1;
      tick(4);
   endtask

   initial begin
      applyStimulus();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
